// File: rtl/bram_arb_pkg.sv
// ============================================================================
// bram_arb_pkg : shared FSM state type and port-index constants for bram_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package bram_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam logic C_PORT0 = 1'b0;
  localparam logic C_PORT1 = 1'b1;

  function automatic arb_state_e lock_state(input logic port);
    return (port == C_PORT1) ? LOCK1 : LOCK0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bram_arb_rr.sv
// ============================================================================
// bram_arb_rr : two-way round-robin grant; BRAM_ARB_FIXED_PRIO_EN selects fixed
//               port-0 priority instead. Rev 1.0
// ============================================================================
`default_nettype none

module bram_arb_rr
  import bram_arb_pkg::*;
(
`ifndef BRAM_ARB_FIXED_PRIO_EN
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] xfer_i,
`endif
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

`ifdef BRAM_ARB_FIXED_PRIO_EN
  assign gnt_o[C_PORT0] = req_i[C_PORT0];
  assign gnt_o[C_PORT1] = req_i[C_PORT1] & ~req_i[C_PORT0];
`else
  // Index of the port that transferred most recently; resets to 1 so port 0 wins first.
  logic last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= C_PORT1;
    end else if (xfer_i[C_PORT0]) begin
      last_q <= C_PORT0;
    end else if (xfer_i[C_PORT1]) begin
      last_q <= C_PORT1;
    end
  end

  always_comb begin
    gnt_o = req_i;
    if (req_i[C_PORT0] && req_i[C_PORT1]) begin
      gnt_o = (last_q == C_PORT1) ? 2'b01 : 2'b10;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/bram_arbiter.sv
// ============================================================================
// bram_arbiter : two requesters sharing one single-port BRAM with burst locking.
//                Optional BRAM_ARB_FIXED_PRIO_EN gives port 0 fixed priority. Rev 1.0
// ============================================================================
`default_nettype none

module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [DATA_WIDTH-1:0] bram_dina,
  input  logic [DATA_WIDTH-1:0] bram_douta
);

  localparam logic [7:0] C_MAX_BURST = 8'(MAX_BURST);

  arb_state_e            state_q;
  logic [7:0]            beat_cnt_q;
  logic [1:0]            rd_pend_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;

  logic [1:0] req_v;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;
  logic [1:0] xfer;
  logic [7:0] beat_inc;
  logic       own;
  logic       own_xfer;
  logic       own_valid;
  logic       own_lock;

  assign req_v = {req1_valid, req0_valid};

  bram_arb_rr u_rr (
`ifndef BRAM_ARB_FIXED_PRIO_EN
    .clk_i  (clka),
    .rst_ni (rsta_n),
    .xfer_i (xfer),
`endif
    .req_i  (req_v),
    .gnt_o  (rr_gnt)
  );

  always_comb begin
    case (state_q)
      LOCK0:   gnt = 2'b01;
      LOCK1:   gnt = 2'b10;
      default: gnt = rr_gnt;
    endcase
  end

  // Gating with reset keeps the BRAM write enable low the instant reset asserts.
  assign req0_ready = rsta_n & gnt[C_PORT0];
  assign req1_ready = rsta_n & gnt[C_PORT1];
  assign xfer       = req_v & {req1_ready, req0_ready};

  assign bram_wea = (xfer[C_PORT0] & req0_we) | (xfer[C_PORT1] & req1_we);

  always_comb begin
    bram_addra = addr_q;
    bram_dina  = din_q;
    if (xfer[C_PORT0]) begin
      bram_addra = req0_addr;
      bram_dina  = req0_wdata;
    end else if (xfer[C_PORT1]) begin
      bram_addra = req1_addr;
      bram_dina  = req1_wdata;
    end
  end

  assign own       = (state_q == LOCK1);
  assign own_xfer  = own ? xfer[C_PORT1] : xfer[C_PORT0];
  assign own_valid = own ? req1_valid : req0_valid;
  assign own_lock  = own ? req1_lock : req0_lock;
  assign beat_inc  = beat_cnt_q + 8'd1;

  assign rsp0_valid = rd_pend_q[C_PORT0];
  assign rsp1_valid = rd_pend_q[C_PORT1];
  assign rsp0_rdata = rd_pend_q[C_PORT0] ? bram_douta : '0;
  assign rsp1_rdata = rd_pend_q[C_PORT1] ? bram_douta : '0;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q    <= ARB;
      beat_cnt_q <= 8'd0;
      rd_pend_q  <= 2'b00;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      rd_pend_q <= xfer & ~{req1_we, req0_we};
      if (|xfer) begin
        addr_q <= bram_addra;
        din_q  <= bram_dina;
      end
      case (state_q)
        ARB: begin
          if (xfer[C_PORT0] && req0_lock) begin
            state_q    <= lock_state(C_PORT0);
            beat_cnt_q <= 8'd1;
          end else if (xfer[C_PORT1] && req1_lock) begin
            state_q    <= lock_state(C_PORT1);
            beat_cnt_q <= 8'd1;
          end
        end
        default: begin
          if (own_xfer) begin
            if (!own_lock || beat_inc == C_MAX_BURST) begin
              state_q    <= ARB;
              beat_cnt_q <= 8'd0;
            end else begin
              beat_cnt_q <= beat_inc;
            end
          end else if (!own_valid && !own_lock) begin
            state_q    <= ARB;
            beat_cnt_q <= 8'd0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_arbiter.sv
// ============================================================================
// tb_bram_arbiter : self-checking bench for bram_arbiter with a BRAM model and
//                   a transaction-level reference. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bram_arbiter;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int MB = 8;

  logic          clka = 1'b0;
  logic          rsta_n;
  logic          req0_valid, req0_ready, req0_we, req0_lock;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_we, req1_lock;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic          bram_wea;
  logic [AW-1:0] bram_addra;
  logic [DW-1:0] bram_dina;
  logic [DW-1:0] bram_douta = '0;

  always #5 clka = ~clka;

  bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clka(clka), .rsta_n(rsta_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_douta(bram_douta)
  );

  // Registered-input BRAM: read data for the address presented in cycle t shows in t+1.
  logic [DW-1:0] bmem [0:(1<<AW)-1] = '{default: '0};
  always @(posedge clka) begin
    if (bram_wea) bmem[bram_addra] <= bram_dina;
    bram_douta <= bmem[bram_addra];
  end

  // Reference state: memory contents, lock owner (-1 none), beats in burst, last winner.
  logic [DW-1:0] refmem [0:(1<<AW)-1];
  int            owner, beats, last;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_din;
  logic [1:0]    exp_rv;
  logic [DW-1:0] exp_rd [2];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic          s_r0, s_r1;

  typedef struct {
    logic v0, v1, lk0, lk1;
    logic e0, e1;   // round-robin expectation
    logic f0, f1;   // fixed-priority expectation
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; beats = 0; last = 1;
    last_addr = '0; last_din = '0;
    exp_rv = 2'b00; exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_we = 0; req0_lock = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_lock = 0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clka); #1;
    rsta_n = 0;
    req0_valid = 1; req0_we = 1; req1_valid = 1; req1_we = 1;
    #1;
    chk("rst_wea", bram_wea, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp0", rsp0_valid, 0);
    chk("rst_rsp1", rsp1_valid, 0);
    idle_inputs();
    repeat (2) @(posedge clka);
    #1 rsta_n = 1;
    model_reset();
  endtask

  task automatic cycle(input logic v0, input logic v1, input logic we0, input logic we1,
                       input logic lk0, input logic lk1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    logic er0, er1, x0, x1, ewe, we, lk;
    logic [AW-1:0] ea, a;
    logic [DW-1:0] ed, d;
    int p;
    @(posedge clka); #1;
    cyc++;
    req0_valid = v0; req0_we = we0; req0_lock = lk0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_lock = lk1; req1_addr = a1; req1_wdata = d1;
    er0 = 0; er1 = 0;
    if (owner == 0) er0 = 1;
    else if (owner == 1) er1 = 1;
    else if (v0 && v1) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
      er0 = 1;
`else
      if (last == 0) er1 = 1; else er0 = 1;
`endif
    end else begin
      er0 = v0; er1 = v1;
    end
    x0 = v0 && er0;
    x1 = v1 && er1;
    ewe = x0 ? we0 : (x1 ? we1 : 1'b0);
    ea  = x0 ? a0 : (x1 ? a1 : last_addr);
    ed  = x0 ? d0 : (x1 ? d1 : last_din);
    @(negedge clka);
    s_r0 = req0_ready; s_r1 = req1_ready;
    chk("ready0", req0_ready, er0);
    chk("ready1", req1_ready, er1);
    chk("wea", bram_wea, ewe);
    chk("addra", bram_addra, ea);
    chk("dina", bram_dina, ed);
    chk("rsp0_valid", rsp0_valid, exp_rv[0]);
    chk("rsp0_rdata", rsp0_rdata, exp_rd[0]);
    chk("rsp1_valid", rsp1_valid, exp_rv[1]);
    chk("rsp1_rdata", rsp1_rdata, exp_rd[1]);
    exp_rv = 2'b00; exp_rd[0] = '0; exp_rd[1] = '0;
    if (x0 || x1) begin
      p  = x0 ? 0 : 1;
      we = x0 ? we0 : we1;
      lk = x0 ? lk0 : lk1;
      a  = x0 ? a0 : a1;
      d  = x0 ? d0 : d1;
      if (we) refmem[a] = d;
      else begin
        exp_rv[p] = 1'b1;
        exp_rd[p] = refmem[a];
      end
      last_addr = a; last_din = d; last = p;
      if (owner < 0) begin
        if (lk) begin owner = p; beats = 1; end
      end else begin
        beats++;
        if (!lk || beats == MB) owner = -1;
      end
    end else if (owner >= 0) begin
      if (!(owner == 0 ? v0 : v1) && !(owner == 0 ? lk0 : lk1)) owner = -1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [12];
    logic r0s [12];
    logic r1s [12];
    int   run;

    for (int i = 0; i < (1 << AW); i++) refmem[i] = '0;
    rsta_n = 0;
    idle_inputs();
    model_reset();
    do_reset();

    // Alternating reads, idle gaps and a short lock on port 1.
    vt[0]  = '{1,1,0,0, 1,0, 1,0};
    vt[1]  = '{1,1,0,0, 0,1, 1,0};
    vt[2]  = '{1,1,0,0, 1,0, 1,0};
    vt[3]  = '{1,1,0,0, 0,1, 1,0};
    vt[4]  = '{1,0,0,0, 1,0, 1,0};
    vt[5]  = '{0,1,0,0, 0,1, 0,1};
    vt[6]  = '{0,0,0,0, 0,0, 0,0};
    vt[7]  = '{1,1,0,0, 1,0, 1,0};
    vt[8]  = '{0,1,0,1, 0,1, 0,1};
    vt[9]  = '{1,1,0,1, 0,1, 0,1};
    vt[10] = '{1,1,0,0, 0,1, 0,1};
    vt[11] = '{1,1,0,0, 1,0, 1,0};
    for (int i = 0; i < 12; i++) begin
      cycle(vt[i].v0, vt[i].v1, 0, 0, vt[i].lk0, vt[i].lk1,
            AW'(i), AW'(i + 32), '0, '0);
`ifdef BRAM_ARB_FIXED_PRIO_EN
      chk("tbl_ready0", s_r0, vt[i].f0);
      chk("tbl_ready1", s_r1, vt[i].f1);
`else
      chk("tbl_ready0", s_r0, vt[i].e0);
      chk("tbl_ready1", s_r1, vt[i].e1);
`endif
    end

    // Write then read-after-write from the other port.
    do_reset();
    cycle(1, 0, 1, 0, 0, 0, 9'h005, 9'h000, 16'hBEEF, 16'h0000);
    cycle(0, 1, 0, 0, 0, 0, 9'h000, 9'h005, 16'h0000, 16'h0000);
    chk("raw_rd_ready1", s_r1, 1);
    cycle(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    chk("raw_rsp1_valid", rsp1_valid, 1);
    chk("raw_rsp1_rdata", rsp1_rdata, 16'hBEEF);

    // Port 0 locked burst against a waiting port 1.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 0, 0, 1, 0, AW'(i), 9'h100, '0, '0);
      r0s[i] = s_r0; r1s[i] = s_r1;
    end
    run = 0;
    for (int i = 0; i < 12; i++) begin
      if (r0s[i] && run == i) run++;
    end
`ifdef BRAM_ARB_FIXED_PRIO_EN
    chk("burst_run", run, 12);
    chk("burst_next_p0", r0s[8], 1);
`else
    chk("burst_run", run, MB);
    chk("burst_next_p1", r1s[8], 1);
`endif

    // Port 1 pauses inside its lock; port 0 must stay blocked.
    do_reset();
    cycle(0, 1, 0, 0, 0, 1, '0, 9'h010, '0, '0);
    chk("lk1_enter", s_r1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 0, 1, 9'h020, 9'h011, '0, '0);
      chk("lk1_hold_ready0", s_r0, 0);
    end
    cycle(1, 1, 0, 0, 0, 1, 9'h020, 9'h012, '0, '0);
    chk("lk1_resume", s_r1, 1);
    cycle(1, 1, 0, 0, 0, 0, 9'h020, 9'h013, '0, '0);
    chk("lk1_last", s_r1, 1);
    cycle(1, 1, 0, 0, 0, 0, 9'h020, 9'h014, '0, '0);
    chk("lk1_release_p0", s_r0, 1);

    // Reset right after an accepted read must swallow the response.
    do_reset();
    cycle(0, 1, 0, 0, 0, 0, '0, 9'h005, '0, '0);
    do_reset();
    chk("post_rst_rsp1", rsp1_valid, 0);
    cycle(1, 1, 0, 0, 0, 0, 9'h001, 9'h002, '0, '0);
    chk("post_rst_first_p0", s_r0, 1);

`ifdef BRAM_ARB_FIXED_PRIO_EN
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 0, 0, 0, 0, AW'(i), AW'(i), '0, '0);
      chk("fixed_p0", s_r0, 1);
    end
`endif

    // Randomised traffic, with a mid-run reset to drop any burst in flight.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic lk_bias;
      if (i == 300) do_reset();
      lk_bias = (i >= 200);
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            lk_bias ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 4) == 0),
            lk_bias ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 4) == 0),
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            DW'($urandom), DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the data width of every data port.
REQ-002 Parameter ADDR_WIDTH, default 9, SHALL set the BRAM address width.
REQ-003 Parameter MAX_BURST, default 8, SHALL be the maximum number of consecutive beats one locked port may hold the BRAM; legal range is 2..255.
REQ-004 Ports (name, direction, width, meaning) SHALL be:
- clka, in, 1: single clock, rising edge.
- rsta_n, in, 1: reset, asynchronous, active-low.
- reqN_valid, in, 1 (N=0,1): request present.
- reqN_ready, out, 1: request accepted this cycle.
- reqN_we, in, 1: 1=write, 0=read.
- reqN_lock, in, 1: keep grant for the next beat (burst).
- reqN_addr, in, ADDR_WIDTH: address.
- reqN_wdata, in, DATA_WIDTH: write data.
- rspN_valid, out, 1: read data valid, single-cycle pulse.
- rspN_rdata, out, DATA_WIDTH: read data.
- bram_wea, out, 1: BRAM write enable.
- bram_addra, out, ADDR_WIDTH: BRAM address.
- bram_dina, out, DATA_WIDTH: BRAM write data.
- bram_douta, in, DATA_WIDTH: BRAM read data.

Function
REQ-005 The block SHALL share one single-port BRAM between requesters 0 and 1. The BRAM registers its inputs, so read data appears on bram_douta in the cycle after the request is presented.
REQ-006 A beat SHALL transfer when reqN_valid and reqN_ready are both 1. At most one reqN_ready SHALL be 1 per cycle.
REQ-007 reqN_ready SHALL be combinational from the current grant and SHALL NOT depend on reqN_ready; no response backpressure exists.
REQ-008 When no port is granted, bram_wea SHALL be 0; bram_addra and bram_dina SHALL hold their last values.
REQ-009 When port N is granted, bram_wea SHALL equal reqN_we, and bram_addra and bram_dina SHALL pass reqN_addr and reqN_wdata through combinationally.
REQ-010 An accepted read SHALL produce rspN_valid=1 exactly one cycle later, with rspN_rdata = bram_douta in that cycle. An accepted write SHALL produce no response.
REQ-011 rspN_rdata SHALL be 0 whenever rspN_valid is 0.
REQ-012 The FSM states SHALL be ARB, LOCK0 and LOCK1.
REQ-013 In ARB, grant SHALL follow round-robin on the last_grant pointer:
- Only one port valid: that port is granted.
- Both ports valid: the port other than last_grant is granted.
- last_grant updates on every transfer.
REQ-014 ARB SHALL go to LOCKN when port N transfers with reqN_lock=1; beat_cnt SHALL load 1.
REQ-015 In LOCKN, only port N SHALL be granted; the other port's ready SHALL be 0 even while port N is idle.
REQ-016 Each transfer in LOCKN SHALL increment beat_cnt.
REQ-017 LOCKN SHALL return to ARB on the first of:
- a transfer with reqN_lock=0;
- a transfer that makes beat_cnt reach MAX_BURST;
- a cycle with reqN_valid=0 and reqN_lock=0.
On return, last_grant SHALL be N, so the other port wins the next contention.
REQ-018 Read-after-write to the same address on consecutive beats SHALL return the newly written data with no stall.
REQ-019 A read issued in the same cycle the BRAM commits an earlier write SHALL return the value committed by that write.

Reset
REQ-020 On rsta_n=0, asynchronously, the block SHALL enter this state:
- state=ARB, last_grant=1 (port 0 wins first contention), beat_cnt=0.
- Read-pending flags cleared.
- rspN_valid=0 and bram_wea=0 immediately.
REQ-021 A read accepted in the cycle before reset asserts SHALL NOT produce a response after reset releases.
REQ-022 Reset asserted mid-burst SHALL abandon the lock without emitting any pending response.

Configuration
REQ-023 With macro BRAM_ARB_FIXED_PRIO_EN defined, ARB SHALL always grant port 0 over port 1, last_grant SHALL be unused, and locking SHALL be unchanged. Without the macro, round-robin per REQ-013 SHALL apply.

Structure
REQ-024 A shared package bram_arb_pkg SHALL hold the state enum (ARB, LOCK0, LOCK1) and the port-index constants.
REQ-025 The two-way round-robin/priority grant logic SHALL be one sub-module, bram_arb_rr, instantiated once.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- After reset, both ports issue a read every cycle with lock=0 -> grants alternate 0,1,0,1; each rspN_valid pulses one cycle after its grant.
- Port 0 writes 0xBEEF to address 0x005, then port 1 reads 0x005 on the next cycle -> rsp1_rdata=0xBEEF, rsp1_valid=1 two cycles after the write was accepted.
- Port 0 holds lock=1 with continuous valid and MAX_BURST=8, port 1 valid -> port 0 gets exactly 8 beats, then port 1 is granted.
- In LOCK1, port 1 drops valid with lock=1 for 3 cycles while port 0 is valid -> port 0 ready stays 0; the burst resumes.
- rsta_n asserted in the cycle after port 1's read is accepted -> rsp1_valid stays 0; the first post-reset contention grants port 0.
- With BRAM_ARB_FIXED_PRIO_EN defined, both ports continuously valid -> port 0 is granted every cycle.
